fifo_deser: RTL and testbench

- Downstream consumer of the 1-bit, 4-deep serial FIFO in MicroEV20.
- Tracks FIFO occupancy by watching the producer's push strobe and its own pops.
- Pops bits as they become available and assembles them MSB-first into WIDTH-bit words.
- Presents each completed word on a valid/ready handshake to the next stage.

---
 rtl/fifo_deser_pkg.sv | 16 +
 rtl/fifo_occ_tracker.sv | 49 ++++
 rtl/fifo_deser.sv | 132 +++++++++++++
 tb/tb_fifo_deser.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_deser_pkg.sv
// rtl/fifo_deser_pkg.sv - shared types, defaults and sizing helper for fifo_deser
package fifo_deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_occ_tracker.sv
// rtl/fifo_occ_tracker.sv - shadow occupancy counter of the upstream FIFO with sticky overflow
module fifo_occ_tracker
  import fifo_deser_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int OW   = occ_width(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  output logic [OW-1:0] occ,
  output logic          overflow
);

  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [OW-1:0] occ_q, occ_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    occ_d      = occ_q;
    overflow_d = overflow_q;
    if (push && !pop) begin
      // A push into a full FIFO is lost by the producer; remember it.
      if (occ_q == FULL) begin
        overflow_d = 1'b1;
      end else begin
        occ_d = occ_q + OW'(1);
      end
    end else if (pop && !push && occ_q != '0) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  assign occ      = occ_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/fifo_deser.sv
// rtl/fifo_deser.sv - pops a 1-bit FIFO and assembles MSB-first words on valid/ready
// FIFO_DESER_PARITY_EN: each frame carries a trailing even-parity bit, reported on parity_err
module fifo_deser
  import fifo_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             fifo_push,
  output logic             fifo_pop,
  input  logic             fifo_p,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow
`ifdef FIFO_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef FIFO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int OW = occ_width(DEPTH);
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             pop_d_q, pop_d_d;
  logic [WIDTH-1:0] word_shift_q, word_shift_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
`ifdef FIFO_DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif
  logic [OW-1:0]    occ;
  logic [WIDTH-1:0] shifted;

  fifo_occ_tracker #(.DEPTH(DEPTH)) u_occ (
    .clk      (clk),
    .clear    (clear),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .occ      (occ),
    .overflow (overflow)
  );

  // Bits already in flight count toward the frame so we never pop past it.
  assign fifo_pop = (state_q == COLLECT) && (occ != '0)
                    && ((bit_cnt_q + CW'(pop_d_q)) < FRAME_C);

  assign shifted = {word_shift_q[WIDTH-2:0], fifo_p};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    pop_d_d      = fifo_pop;
    word_shift_d = word_shift_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
`ifdef FIFO_DESER_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      COLLECT: begin
        if (pop_d_q) begin
          word_shift_d = shifted;
          if (bit_cnt_q + CW'(1) == FRAME_C) begin
            bit_cnt_d    = '0;
            word_valid_d = 1'b1;
            state_d      = HOLD;
`ifdef FIFO_DESER_PARITY_EN
            // Final bit is parity; the data bits are already in the shifter.
            word_out_d   = word_shift_q;
            parity_err_d = ^{word_shift_q, fifo_p};
`else
            word_out_d   = shifted;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (word_valid_q && word_ready) begin
          word_valid_d = 1'b0;
          state_d      = COLLECT;
`ifdef FIFO_DESER_PARITY_EN
          parity_err_d = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= COLLECT;
      bit_cnt_q    <= '0;
      pop_d_q      <= 1'b0;
      word_shift_q <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
`ifdef FIFO_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      pop_d_q      <= pop_d_d;
      word_shift_q <= word_shift_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
`ifdef FIFO_DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
`ifdef FIFO_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_fifo_deser.sv
// tb/tb_fifo_deser.sv - self-checking bench for fifo_deser with a 4-deep FIFO model
module tb_fifo_deser;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
`ifdef FIFO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk;
  logic             clear;
  logic             fifo_push;
  logic             push_data;
  logic             fifo_pop;
  logic             fifo_p;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             overflow;
`ifdef FIFO_DESER_PARITY_EN
  logic             parity_err;
`endif

  int tests = 0;
  int fails = 0;

  fifo_deser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clear      (clear),
    .fifo_push  (fifo_push),
    .fifo_pop   (fifo_pop),
    .fifo_p     (fifo_p),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow)
`ifdef FIFO_DESER_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFO plus the stream of bits it actually accepted.
  bit mq[$];
  bit exp_bits[$];
  bit exp_ovf = 1'b0;
  int pop_cnt = 0;

  always @(posedge clk) begin
    if (clear) begin
      mq.delete();
      exp_bits.delete();
      exp_ovf = 1'b0;
      fifo_p <= 1'b0;
    end else begin
      if (fifo_push && !fifo_pop && mq.size() == DEPTH) exp_ovf = 1'b1;
      if (fifo_pop) begin
        pop_cnt++;
        if (mq.size() > 0) fifo_p <= mq.pop_front();
      end
      if (fifo_push && mq.size() < DEPTH) begin
        mq.push_back(push_data);
        exp_bits.push_back(push_data);
      end
    end
  end

  // Word monitor: each new word must be the next FRAME accepted bits, MSB first.
  int               word_cnt = 0;
  int               valid_cycles = 0;
  logic             valid_prev = 1'b0;
  logic [WIDTH-1:0] held_word = '0;
  logic [WIDTH-1:0] mon_w;
  bit               mon_par;
  bit               mon_b;

  always @(negedge clk) begin
    if (fifo_pop) check("pop_nonempty", 32'(mq.size() != 0), 32'd1);
    if (word_valid) begin
      valid_cycles++;
      check("no_pop_in_hold", 32'(fifo_pop), 32'd0);
      if (!valid_prev) begin
        check("word_bits_avail", 32'(exp_bits.size() >= FRAME), 32'd1);
        if (exp_bits.size() >= FRAME) begin
          mon_w   = '0;
          mon_par = 1'b0;
          for (int i = 0; i < WIDTH; i++) begin
            mon_b   = exp_bits.pop_front();
            mon_w   = {mon_w[WIDTH-2:0], mon_b};
            mon_par = mon_par ^ mon_b;
          end
`ifdef FIFO_DESER_PARITY_EN
          mon_b   = exp_bits.pop_front();
          mon_par = mon_par ^ mon_b;
          check("parity_err", 32'(parity_err), 32'(mon_par));
`endif
          check("word_data", 32'(word_out), 32'(mon_w));
          held_word = mon_w;
        end
        word_cnt++;
      end else begin
        check("word_held", 32'(word_out), 32'(held_word));
      end
    end
    valid_prev = word_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic push_bits(input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      fifo_push = 1'b1;
      push_data = bits[i];
      tick();
      fifo_push = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w, input int gap);
    push_bits(16'(w), WIDTH, gap);
`ifdef FIFO_DESER_PARITY_EN
    push_bits(16'(^w), 1, gap);
`endif
  endtask

  task automatic wait_words(input int n, input string tag);
    int k;
    k = 0;
    while (word_cnt < n && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(word_cnt >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int               w0;
  int               base;
  int               vc0;
  int               k;
  logic [WIDTH-1:0] rw;

  initial begin
    clear = 1'b1;
    fifo_push = 1'b0;
    push_data = 1'b0;
    word_ready = 1'b0;
    tick();
    tick();
    check("rst_pop", 32'(fifo_pop), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_occ", 32'(dut.occ), 32'd0);
    check("rst_bitcnt", 32'(dut.bit_cnt_q), 32'd0);
    clear = 1'b0;

    // Back-to-back stream with ready high.
    word_ready = 1'b1;
    w0 = word_cnt;
    base = pop_cnt;
    vc0 = valid_cycles;
    push_word(4'b1011, 0);
    wait_words(w0 + 1, "t1_wait");
    repeat (4) tick();
    check("t1_word", 32'(word_out), 32'hb);
    check("t1_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
    check("t1_pops", 32'(pop_cnt - base), 32'(FRAME));
    check("t1_occ", 32'(dut.occ), 32'd0);

    // Hold with ready low; pushes continue to fill the FIFO.
    do_clear();
    word_ready = 1'b0;
    w0 = word_cnt;
    push_word(4'b1100, 0);
    push_bits(16'hA, 4, 0);
    wait_words(w0 + 1, "t2_wait1");
    base = pop_cnt;
    repeat (10) tick();
    check("t2_hold_word", 32'(word_out), 32'hc);
    check("t2_hold_valid", 32'(word_valid), 32'd1);
    check("t2_hold_pops", 32'(pop_cnt - base), 32'd0);
    check("t2_occ", 32'(dut.occ), 32'(mq.size()));
    check("t2_ovf", 32'(overflow), 32'd0);
    word_ready = 1'b1;
`ifdef FIFO_DESER_PARITY_EN
    push_bits(16'h0, 1, 0);
`endif
    wait_words(w0 + 2, "t2_wait2");
    check("t2_word2", 32'(word_out), 32'ha);

    // Sparse pushes: one every 3 cycles.
    do_clear();
    word_ready = 1'b1;
    w0 = word_cnt;
    rw = WIDTH'($urandom);
    push_word(rw, 2);
    wait_words(w0 + 1, "t3_wait");
    repeat (3) tick();
    check("t3_word", 32'(word_out), 32'(rw));
    check("t3_occ", 32'(dut.occ), 32'd0);

    // Overflow while HOLD blocks pops.
    do_clear();
    word_ready = 1'b0;
    w0 = word_cnt;
    push_word(WIDTH'($urandom), 0);
    wait_words(w0 + 1, "t4_wait");
    repeat (3) tick();
    push_bits(16'($urandom), 4, 0);
    check("t4_ovf_at_full", 32'(overflow), 32'd0);
    check("t4_occ_full", 32'(dut.occ), 32'd4);
    push_bits(16'd1, 1, 0);
    check("t4_ovf_set", 32'(overflow), 32'd1);
    check("t4_ovf_model", 32'(overflow), 32'(exp_ovf));
    check("t4_occ_sat", 32'(dut.occ), 32'd4);
    word_ready = 1'b1;
    repeat (20) tick();
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    do_clear();
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // Clear after two captured bits discards the partial word.
    word_ready = 1'b1;
    push_bits(16'h2, 2, 0);
    k = 0;
    while (dut.bit_cnt_q != 2 && k < 20) begin
      tick();
      k++;
    end
    check("t5_two_bits", 32'(dut.bit_cnt_q), 32'd2);
    do_clear();
    check("t5_occ", 32'(dut.occ), 32'd0);
    check("t5_bitcnt", 32'(dut.bit_cnt_q), 32'd0);
    check("t5_valid", 32'(word_valid), 32'd0);
    w0 = word_cnt;
    rw = WIDTH'($urandom);
    push_word(rw, 0);
    wait_words(w0 + 1, "t5_wait");
    repeat (2) tick();
    check("t5_word", 32'(word_out), 32'(rw));

`ifdef FIFO_DESER_PARITY_EN
    // Good and bad parity frames.
    do_clear();
    word_ready = 1'b0;
    w0 = word_cnt;
    push_bits(16'h17, 5, 0);
    wait_words(w0 + 1, "t6_wait1");
    check("t6_par_ok", 32'(parity_err), 32'd0);
    check("t6_word1", 32'(word_out), 32'hb);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    push_bits(16'h16, 5, 0);
    wait_words(w0 + 2, "t6_wait2");
    check("t6_par_bad", 32'(parity_err), 32'd1);
    check("t6_word2", 32'(word_out), 32'hb);
    word_ready = 1'b1;
    repeat (2) tick();
    check("t6_par_clr", 32'(parity_err), 32'd0);
`endif

    // Random traffic against the model.
    do_clear();
    w0 = word_cnt;
    for (int i = 0; i < 400; i++) begin
      fifo_push  = 1'($urandom);
      push_data  = 1'($urandom);
      word_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    fifo_push = 1'b0;
    word_ready = 1'b1;
    repeat (20) tick();
    check("rand_ovf", 32'(overflow), 32'(exp_ovf));
    check("rand_occ", 32'(dut.occ), 32'(mq.size()));
    check("rand_progress", 32'(word_cnt > w0 + 10), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
